// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, oversampling constants
// and the baud divisor function used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
    localparam int unsigned SAMPLE_LO  = 7;
    localparam int unsigned SAMPLE_MID = 8;
    localparam int unsigned SAMPLE_HI  = 9;

    // Clocks per oversample tick, rounded to nearest, never below 2.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        int unsigned d;
        d = (clk_hz + 8 * baud) / (OVERSAMPLE * baud);
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO.
//  clk, reset_n : clock, async active-low reset
//  push, din    : write request and data (ignored when full unless popping)
//  pop          : read request, honoured only when not empty
//  dout         : registered head entry, valid while !empty
//  empty, full  : registered status
//  count        : registered occupancy, 0..DEPTH
module uart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             do_pop_c;
    logic             do_push_c;
    logic [PTR_W-1:0] rd_ptr_nxt_c;
    logic [CNT_W-1:0] count_nxt_c;
    logic [WIDTH-1:0] head_nxt_c;

    // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
    always_comb begin
        do_pop_c     = pop && !empty;
        do_push_c    = push && (!full || do_pop_c);
        rd_ptr_nxt_c = do_pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt_c  = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        // New head comes from the write port when it lands in the slot the head moves to.
        head_nxt_c   = (do_push_c && (wr_ptr == rd_ptr_nxt_c)) ? din : mem[rd_ptr_nxt_c];
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt_c;
            count  <= count_nxt_c;
            empty  <= (count_nxt_c == '0);
            full   <= (count_nxt_c == CNT_W'(DEPTH));
            if (count_nxt_c != '0) begin
                dout <= head_nxt_c;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver with a FWFT receive buffer.
// Build option: UART_RX_PARITY_EN adds a parity bit to the frame and the P_ODD port.
//  clk, reset_n : clock, async active-low reset
//  rx           : serial line, idle high, asynchronous
//  rd_en        : pop request; rd_data/empty/full/count report the buffer
//  overrun, frame_err, parity_err : sticky error flags, cleared by err_clr
//  P_ODD        : (parity builds only) 1 = odd parity, 0 = even
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err,
`ifdef UART_RX_PARITY_EN
    input  logic                          P_ODD,
`endif
    input  logic                          err_clr
);

    localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD);
    localparam int unsigned DIV_W = $clog2(DIV);

    logic [1:0]       rx_sync;
    logic [1:0]       sync_vld;
    logic             armed;
    logic             rx_s;

    rx_state_t        state;
    rx_state_t        state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0]  os_cnt;
    logic             s_lo;
    logic             s_mid;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;

    logic             counting_c;
    logic             tick_c;
    logic             bit_done_c;
    logic             maj_c;
    logic             start_c;
    logic             shift_c;
    logic             push_c;
    logic             ferr_set_c;

    assign rx_s = rx_sync[1];

    // Two-flop synchronizer; armed only once the line has been seen high after
    // reset, so a line held low through reset release is not taken as a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync  <= 2'b11;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Tick timing and 3-sample majority; every bit decision happens at tick 9.
    always_comb begin
        counting_c = (state != IDLE) && (state != BREAK);
        tick_c     = (div_cnt == DIV_W'(DIV - 1));
        bit_done_c = tick_c && (os_cnt == OS_W'(SAMPLE_HI));
        maj_c      = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and datapath controls
    always_comb begin
        state_nxt  = state;
        start_c    = 1'b0;
        shift_c    = 1'b0;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_nxt = START;
                    start_c   = 1'b1;
                end
            end
            START: begin
                if (bit_done_c) begin
                    state_nxt = maj_c ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    shift_c = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done_c) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done_c) begin
                    if (maj_c) begin
                        push_c    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_nxt  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Divisor/oversample counters, samples and data shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            os_cnt  <= '0;
            s_lo    <= 1'b1;
            s_mid   <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            if (start_c) begin
                div_cnt <= '0;
                os_cnt  <= '0;
                bit_idx <= '0;
            end else if (counting_c) begin
                if (tick_c) begin
                    div_cnt <= '0;
                    os_cnt  <= os_cnt + OS_W'(1);
                    if (os_cnt == OS_W'(SAMPLE_LO)) begin
                        s_lo <= rx_s;
                    end
                    if (os_cnt == OS_W'(SAMPLE_MID)) begin
                        s_mid <= rx_s;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
            if (shift_c) begin
                shreg   <= {maj_c, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    // Parity result is held until the stop bit decides whether the byte is pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad <= 1'b0;
        end else if (start_c) begin
            par_bad <= 1'b0;
        end else if ((state == PARITY) && bit_done_c) begin
            par_bad <= ((^shreg) ^ maj_c) != P_ODD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if (push_c && par_bad) begin
            parity_err <= 1'b1;
        end else if (err_clr) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Sticky flags; a set beats a simultaneous clear. Push and pop together never overruns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_c && full && !(rd_en && !empty)) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (ferr_set_c) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .din     (shreg),
        .pop     (rd_en),
        .dout    (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: DIV = 10, one bit = 160 clk.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_HZ = 25000000;
    localparam int unsigned BAUD   = CLK_HZ / 160;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned BITCLK = 160;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;
    logic       p_odd;
    logic       err_clr;

    int n_checks;
    int n_fail;

    logic [7:0] mq[$];
    logic       m_ovr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         pops;
        logic       clr;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err),
`ifdef UART_RX_PARITY_EN
        .P_ODD      (p_odd),
`endif
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame, one bit per 160 negedges. With pop_at_stop, rd_en is high
    // for exactly the clk in which the receiver decides the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                              input bit pop_at_stop);
        logic [10:0] fr;
        int nb;
        int pop_at;
        fr     = PAR_EN ? {stop_v, par_v, d, 1'b0} : {1'b1, stop_v, d, 1'b0};
        nb     = PAR_EN ? 11 : 10;
        pop_at = (nb - 1) * BITCLK + 102;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < BITCLK; c++) begin
                @(negedge clk);
                rx = fr[b];
                if (pop_at_stop) rd_en = (b * BITCLK + c == pop_at);
            end
        end
        rd_en = 1'b0;
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ p_odd;
    endfunction

    task automatic idle_line(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic pulse_pop();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    function automatic void model_push(input logic [7:0] d);
        if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(d);
    endfunction

    initial begin
        logic [7:0] d;
        int npop;
        n_checks = 0;
        n_fail   = 0;
        m_ovr    = 1'b0;
        p_odd    = 1'b0;
        reset_n  = 1'b0;
        rx       = 1'b1;
        rd_en    = 1'b0;
        err_clr  = 1'b0;

        vecs[0] = '{8'hC3, 1'b1, 0, 1'b0, 1, 8'hC3, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1'b0, 1, 8'hC3, 1'b1};
        vecs[2] = '{8'h55, 1'b1, 0, 1'b1, 2, 8'hC3, 1'b0};
        vecs[3] = '{8'h0F, 1'b1, 2, 1'b0, 1, 8'h0F, 1'b0};
        vecs[4] = '{8'hF0, 1'b1, 1, 1'b0, 1, 8'hF0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'h00);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        reset_n = 1'b1;
        idle_line(20);

        // Single byte in and out
        send_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b0);
        check("a5_empty", 32'(empty), 32'd0);
        check("a5_rd_data", 32'(rd_data), 32'hA5);
        check("a5_count", 32'(count), 32'd1);
        check("a5_flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
        pulse_pop();
        check("a5_pop_empty", 32'(empty), 32'd1);

        // Short low glitch is rejected; a following frame is still received
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle_line(400);
        check("glitch_empty", 32'(empty), 32'd1);
        check("glitch_frame_err", 32'(frame_err), 32'd0);
        send_frame(8'h96, 1'b1, good_par(8'h96), 1'b0);
        check("after_glitch_rd_data", 32'(rd_data), 32'h96);
        check("after_glitch_count", 32'(count), 32'd1);
        pulse_pop();

        // Framing error followed by long break, then recovery
        send_frame(8'h3C, 1'b0, good_par(8'h3C), 1'b0);
        repeat (2000) @(negedge clk);
        check("break_frame_err", 32'(frame_err), 32'd1);
        check("break_count", 32'(count), 32'd0);
        idle_line(20);
        send_frame(8'h55, 1'b1, good_par(8'h55), 1'b0);
        check("recover_rd_data", 32'(rd_data), 32'h55);
        check("recover_count", 32'(count), 32'd1);
        check("recover_ferr_sticky", 32'(frame_err), 32'd1);
        pulse_clr();
        check("err_clr_frame_err", 32'(frame_err), 32'd0);
        pulse_pop();

        // Table of single-frame scenarios
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, good_par(vecs[i].data), 1'b0);
            idle_line(20);
            for (int p = 0; p < vecs[i].pops; p++) pulse_pop();
            if (vecs[i].clr) pulse_clr();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            if (vecs[i].exp_count > 0)
                check($sformatf("vec%0d_head", i), 32'(rd_data), 32'(vecs[i].exp_head));
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
        end
        pulse_pop();
        check("table_drain_empty", 32'(empty), 32'd1);

        // Randomised bytes and reads against the queue model
        mq.delete();
        m_ovr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle_line($urandom_range(0, 40));
            d = 8'($urandom);
            send_frame(d, 1'b1, good_par(d), 1'b0);
            model_push(d);
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                if (mq.size() > 0) begin
                    check($sformatf("rand%0d_rd_data", i), 32'(rd_data), 32'(mq[0]));
                    void'(mq.pop_front());
                end
                pulse_pop();
            end
            check($sformatf("rand%0d_count", i), 32'(count), 32'(mq.size()));
        end
        check("rand_overrun", 32'(overrun), 32'(m_ovr));
        while (mq.size() > 0) begin
            check("rand_drain", 32'(rd_data), 32'(mq.pop_front()));
            pulse_pop();
        end
        check("rand_drain_empty", 32'(empty), 32'd1);

        // Fill past capacity: 17th byte is dropped
        for (int i = 0; i < 17; i++) begin
            d = 8'(i);
            send_frame(d, 1'b1, good_par(d), 1'b0);
            model_push(d);
        end
        check("ovr_full", 32'(full), 32'd1);
        check("ovr_count", 32'(count), 32'(mq.size()));
        check("ovr_overrun", 32'(overrun), 32'(m_ovr));
        check("ovr_head", 32'(rd_data), 32'(mq[0]));
        pulse_clr();
        m_ovr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Pop in the stop-decision clk of a full FIFO: push accepted, no overrun
        send_frame(8'h77, 1'b1, good_par(8'h77), 1'b1);
        void'(mq.pop_front());
        mq.push_back(8'h77);
        check("popfull_count", 32'(count), 32'd16);
        check("popfull_overrun", 32'(overrun), 32'd0);
        check("popfull_full", 32'(full), 32'd1);
        while (mq.size() > 0) begin
            check("popfull_drain", 32'(rd_data), 32'(mq.pop_front()));
            pulse_pop();
        end
        check("popfull_drain_empty", 32'(empty), 32'd1);

        // Reset mid-DATA with bytes held and a flag set; line low across release
        send_frame(8'h11, 1'b1, good_par(8'h11), 1'b0);
        send_frame(8'h22, 1'b0, good_par(8'h22), 1'b0);
        idle_line(20);
        check("prereset_count", 32'(count), 32'd1);
        check("prereset_frame_err", 32'(frame_err), 32'd1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_empty", 32'(empty), 32'd1);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_rd_data", 32'(rd_data), 32'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("lowrelease_empty", 32'(empty), 32'd1);
        idle_line(200);
        send_frame(8'h5A, 1'b1, good_par(8'h5A), 1'b0);
        check("postreset_count", 32'(count), 32'd1);
        check("postreset_rd_data", 32'(rd_data), 32'h5A);
        check("postreset_flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
        pulse_pop();

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x01 needs parity bit 1
        p_odd = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        check("par_bad_count", 32'(count), 32'd1);
        check("par_bad_flag", 32'(parity_err), 32'd1);
        pulse_pop();
        pulse_clr();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        check("par_ok_count", 32'(count), 32'd1);
        check("par_ok_flag", 32'(parity_err), 32'd0);
        pulse_pop();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
